// File: rtl/multicycle_core_pkg.sv
// multicycle_core_pkg: opcodes, FSM/ALU encodings and instruction field helpers for multicycle_core
package multicycle_core_pkg;
   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_e;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_PASS} alu_op_e;
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LI    = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_SUB   = 4'h3;
   localparam logic [3:0] OP_MOV   = 4'h4;
   localparam logic [3:0] OP_LW    = 4'h5;
   localparam logic [3:0] OP_SW    = 4'h6;
   localparam logic [3:0] OP_ADDSP = 4'h7;
   localparam logic [3:0] OP_BEQ   = 4'h8;
   localparam logic [3:0] OP_JAL   = 4'h9;
   localparam logic [3:0] OP_JR    = 4'hA;
   localparam logic [3:0] OP_HALT  = 4'hF;
   function automatic int imm_w(input int w);
      return w - 4;
   endfunction
   function automatic int op_lsb(input int w);
      return w - 4;
   endfunction
endpackage

// File: rtl/multicycle_core_alu.sv
// multicycle_core_alu: add/subtract/pass-through with signed overflow and zero flags
module multicycle_core_alu import multicycle_core_pkg::*; #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  alu_op_e          op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             overflow_o,
   output logic             zero_o
);
   always_comb begin
      result_o   = op_i == ALU_ADD ? a_i + b_i : op_i == ALU_SUB ? a_i - b_i : a_i;
      overflow_o = op_i == ALU_ADD ? (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]) :
                   op_i == ALU_SUB ? (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]) : 1'b0;
      zero_o     = result_o == '0;
   end
endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: fetch/execute FSM core with a request/ready memory port.
// Define MULTICYCLE_CORE_TRAP_ILLEGAL_EN to trap opcodes B-E into HALTED with illegal=1.
module multicycle_core import multicycle_core_pkg::*; #(
   parameter int                WIDTH    = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] RESET_SP = {ADDR_W{1'b1}}
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   input  logic              mem_ready,
   output logic [WIDTH-1:0]  instruction,
   output logic [ADDR_W-1:0] pc_out,
   output logic              overflow_output,
   output logic              halted,
   output logic              illegal
);
   localparam int IW = imm_w(WIDTH);
   state_e            state_q;
   logic [ADDR_W-1:0] pc_q, sp_q, addr_q;
   logic [WIDTH-1:0]  ir_q, mary_q, shelley_q, comp_q, ra_q;
   logic              ovf_q;
   logic [3:0]        op;
   logic [WIDTH-1:0]  imm_z, imm_s, sp_off, pc_off, alu_a, alu_res;
   logic [ADDR_W-1:0] ea, br_pc;
   alu_op_e           alu_op;
   logic              alu_ovf, alu_zero;
   always_comb begin
      op     = ir_q[WIDTH-1 -: 4];
      imm_z  = WIDTH'(ir_q[IW-1:0]);
      imm_s  = {{4{ir_q[IW-1]}}, ir_q[IW-1:0]};
      sp_off = WIDTH'(sp_q) + imm_s;
      pc_off = WIDTH'(pc_q) + imm_s;
      ea     = sp_off[ADDR_W-1:0];
      br_pc  = pc_off[ADDR_W-1:0];
      alu_op = op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : ALU_PASS;
      // pass-through of comp gives the BEQ zero test for free
      alu_a  = alu_op == ALU_PASS ? comp_q : mary_q;
   end
   multicycle_core_alu #(.WIDTH(WIDTH)) u_alu (
      .a_i(alu_a), .b_i(shelley_q), .op_i(alu_op),
      .result_o(alu_res), .overflow_o(alu_ovf), .zero_o(alu_zero)
   );
   // reset gates the request directly so a pending transfer drops in the same cycle
   assign mem_req         = !reset && (state_q == FETCH || state_q == MEM);
   assign mem_we          = state_q == MEM && op == OP_SW;
   assign mem_addr        = state_q == FETCH ? pc_q : addr_q;
   assign mem_wdata       = comp_q;
   assign instruction     = ir_q;
   assign pc_out          = pc_q;
   assign overflow_output = ovf_q;
   assign halted          = state_q == HALTED;
`ifdef MULTICYCLE_CORE_TRAP_ILLEGAL_EN
   logic ill_q;
   assign illegal = ill_q;
`else
   assign illegal = 1'b0;
`endif
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         sp_q      <= RESET_SP;
         addr_q    <= '0;
         ir_q      <= '0;
         mary_q    <= '0;
         shelley_q <= '0;
         comp_q    <= '0;
         ra_q      <= '0;
         ovf_q     <= 1'b0;
`ifdef MULTICYCLE_CORE_TRAP_ILLEGAL_EN
         ill_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            FETCH: if (mem_ready) begin
               ir_q    <= mem_rdata;
               pc_q    <= pc_q + ADDR_W'(1);
               state_q <= EXEC;
            end
            EXEC: begin
               state_q <= FETCH;
               case (op)
                  OP_LI:          mary_q <= imm_z;
                  OP_ADD, OP_SUB: begin comp_q <= alu_res; ovf_q <= alu_ovf; end
                  OP_MOV:         shelley_q <= comp_q;
                  OP_LW, OP_SW:   begin addr_q <= ea; state_q <= MEM; end
                  OP_ADDSP:       sp_q <= ea;
                  OP_BEQ:         if (alu_zero) pc_q <= br_pc;
                  OP_JAL:         begin ra_q <= WIDTH'(pc_q); pc_q <= imm_z[ADDR_W-1:0]; end
                  OP_JR:          pc_q <= ra_q[ADDR_W-1:0];
                  OP_HALT:        state_q <= HALTED;
`ifdef MULTICYCLE_CORE_TRAP_ILLEGAL_EN
                  4'hB, 4'hC, 4'hD, 4'hE: begin state_q <= HALTED; ill_q <= 1'b1; end
`endif
                  default: ;
               endcase
            end
            MEM: if (mem_ready) begin
               if (op == OP_LW) mary_q <= mem_rdata;
               state_q <= FETCH;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: table-driven program run plus directed wait-state, branch, halt and reset sequences
module tb_multicycle_core;
   logic clock = 1'b0, reset = 1'b1, mem_ready = 1'b1;
   logic mem_req, mem_we, overflow_output, halted, illegal;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, instruction, pc_out;
   logic [15:0] mem [0:65535];
   int n_cmp = 0, n_bad = 0;

   multicycle_core dut (
      .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instruction(instruction),
      .pc_out(pc_out), .overflow_output(overflow_output), .halted(halted), .illegal(illegal)
   );

   always #5 clock = ~clock;
   assign mem_rdata = mem[mem_addr];
   always @(posedge clock) if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] ad, ins, pc;
      logic        ov;
      logic [15:0] ea, wd;
   } vec_t;
   vec_t v [24];

   initial begin
      v = '{
         '{16'h0000, 16'h1005, 16'h0001, 1'b0, 16'h0000, 16'h0000},
         '{16'h0001, 16'h2000, 16'h0002, 1'b0, 16'h0000, 16'h0000},
         '{16'h0002, 16'h6FFD, 16'h0003, 1'b0, 16'hFFFC, 16'h0005},
         '{16'h0003, 16'h5FFF, 16'h0004, 1'b0, 16'hFFFE, 16'h0005},
         '{16'h0004, 16'h2000, 16'h0005, 1'b0, 16'h0000, 16'h0000},
         '{16'h0005, 16'h4000, 16'h0006, 1'b0, 16'h0000, 16'h0000},
         '{16'h0006, 16'h1001, 16'h0007, 1'b0, 16'h0000, 16'h0000},
         '{16'h0007, 16'h2000, 16'h0008, 1'b1, 16'h0000, 16'h0000},
         '{16'h0008, 16'h6FFD, 16'h0009, 1'b1, 16'hFFFC, 16'h8000},
         '{16'h0009, 16'h5FFD, 16'h000A, 1'b1, 16'hFFFC, 16'h8000},
         '{16'h000A, 16'h3000, 16'h000B, 1'b1, 16'h0000, 16'h0000},
         '{16'h000B, 16'h4000, 16'h000C, 1'b1, 16'h0000, 16'h0000},
         '{16'h000C, 16'h1001, 16'h000D, 1'b1, 16'h0000, 16'h0000},
         '{16'h000D, 16'h3000, 16'h000E, 1'b0, 16'h0000, 16'h0000},
         '{16'h000E, 16'h6FFD, 16'h000F, 1'b0, 16'hFFFC, 16'h0000},
         '{16'h000F, 16'h8001, 16'h0011, 1'b0, 16'h0000, 16'h0000},
         '{16'h0011, 16'h7FFE, 16'h0012, 1'b0, 16'h0000, 16'h0000},
         '{16'h0012, 16'h1003, 16'h0013, 1'b0, 16'h0000, 16'h0000},
         '{16'h0013, 16'h2000, 16'h0014, 1'b0, 16'h0000, 16'h0000},
         '{16'h0014, 16'h8005, 16'h0015, 1'b0, 16'h0000, 16'h0000},
         '{16'h0015, 16'h9020, 16'h0020, 1'b0, 16'h0000, 16'h0000},
         '{16'h0020, 16'h6000, 16'h0021, 1'b0, 16'hFFFD, 16'h0004},
         '{16'h0021, 16'hA000, 16'h0016, 1'b0, 16'h0000, 16'h0000},
         '{16'h0016, 16'hB000, 16'h0017, 1'b0, 16'h0000, 16'h0000}
      };
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
      for (int i = 0; i < 24; i++) mem[v[i].ad] <= v[i].ins;
      mem[16'h0010] <= 16'hF000;
      mem[16'h0017] <= 16'hF000;
      mem[16'hFFFE] <= 16'h7FFF;
      @(negedge clock);
      chk("rst_req", 16'(mem_req), 16'h0);
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_ir", instruction, 16'h0000);
      chk("rst_flags", {13'b0, overflow_output, halted, illegal}, 16'h0);
      reset = 1'b0;
      #1;
      chk("first_req", 16'(mem_req), 16'h1);
      chk("first_addr", mem_addr, 16'h0000);
      // first 23 entries: each is FETCH->EXEC(->MEM)->next FETCH with ready held high
      for (int i = 0; i < 23; i++) begin
         @(negedge clock);
         chk("exec_ir", instruction, v[i].ins);
         chk("exec_pc", pc_out, v[i].ad + 16'd1);
         chk("exec_req", 16'(mem_req), 16'h0);
         if (v[i].ins[15:12] == 4'h5 || v[i].ins[15:12] == 4'h6) begin
            @(negedge clock);
            chk("mem_req", 16'(mem_req), 16'h1);
            chk("mem_we", 16'(mem_we), 16'(v[i].ins[15:12] == 4'h6));
            chk("mem_addr", mem_addr, v[i].ea);
            chk("mem_wdata", mem_wdata, v[i].wd);
         end
         @(negedge clock);
         chk("next_pc", pc_out, v[i].pc);
         chk("next_fetch_addr", mem_addr, v[i].pc);
         chk("ovf", 16'(overflow_output), 16'(v[i].ov));
      end
      chk("sw_result", mem[16'hFFFD], 16'h0004);
      @(negedge clock);
      chk("ill_ir", instruction, 16'hB000);
`ifdef MULTICYCLE_CORE_TRAP_ILLEGAL_EN
      @(negedge clock);
      chk("trap_halted", 16'(halted), 16'h1);
      chk("trap_illegal", 16'(illegal), 16'h1);
      chk("trap_pc", pc_out, 16'h0017);
`else
      @(negedge clock);
      chk("nop_pc", pc_out, 16'h0017);
      chk("nop_req", 16'(mem_req), 16'h1);
      chk("nop_illegal", 16'(illegal), 16'h0);
      @(negedge clock);
      chk("halt_ir", instruction, 16'hF000);
      @(negedge clock);
      chk("halt_halted", 16'(halted), 16'h1);
`endif
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         chk("halt_quiet", {14'b0, mem_req, halted}, 16'h1);
      end
      // fetch with three wait states
      reset = 1'b1;
      #1;
      chk("rst_halted", {14'b0, halted, illegal}, 16'h0);
      @(negedge clock);
      mem_ready = 1'b0;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("wait_req", 16'(mem_req), 16'h1);
         chk("wait_addr", mem_addr, 16'h0000);
         chk("wait_pc", pc_out, 16'h0000);
         chk("wait_ir", instruction, 16'h0000);
         if (k == 3) mem_ready = 1'b1;
         @(negedge clock);
      end
      chk("wait_done_ir", instruction, 16'h1005);
      chk("wait_done_pc", pc_out, 16'h0001);
      // backward branch: BEQ -2 fetched at pc 4
      reset = 1'b1;
      mem[0] <= 16'h2000;
      mem[1] <= 16'h0000;
      mem[2] <= 16'h0000;
      mem[3] <= 16'h0000;
      mem[4] <= 16'h8FFE;
      @(negedge clock);
      reset = 1'b0;
      repeat (9) @(negedge clock);
      chk("beq_ir", instruction, 16'h8FFE);
      chk("beq_exec_pc", pc_out, 16'h0005);
      @(negedge clock);
      chk("beq_pc", pc_out, 16'h0003);
      // reset during a stalled store
      reset = 1'b1;
      mem[0] <= 16'h6FFD;
      mem[16'hFFFC] <= 16'hAAAA;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      mem_ready = 1'b0;
      @(negedge clock);
      chk("sw_wait_req", {14'b0, mem_req, mem_we}, 16'h3);
      chk("sw_wait_addr", mem_addr, 16'hFFFC);
      @(negedge clock);
      chk("sw_hold_addr", mem_addr, 16'hFFFC);
      reset = 1'b1;
      #1;
      chk("midrst_req", {14'b0, mem_req, mem_we}, 16'h0);
      chk("midrst_pc", pc_out, 16'h0000);
      chk("midrst_ir", instruction, 16'h0000);
      chk("midrst_flags", {13'b0, overflow_output, halted, illegal}, 16'h0);
      @(negedge clock);
      chk("midrst_nowrite", mem[16'hFFFC], 16'hAAAA);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised successor of the hand-sequenced datapath: the PC/SP, instruction register, mary/shelley/comp/ra registers and ALU are retained, with an integrated fetch/execute control FSM replacing the external control strobes.
- The memory port is a single-port request/ready handshake that tolerates wait states. It is no longer a zero-latency array.
- Sits at top of processor hierarchy; memory/peripherals attach outside.

Parameters:
- WIDTH, 16, data/instruction/register width (>=12)
- ADDR_W, 16, memory word-address width (<=WIDTH); addresses are low ADDR_W bits of computed values
- RESET_PC, 0, PC value after reset
- RESET_SP, {ADDR_W{1'b1}}, SP value after reset

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write, 0=read; valid with mem_req
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WIDTH  write data (comp)
- mem_rdata  in  WIDTH  read data, valid when mem_req&&mem_ready
- mem_ready  in  1  transfer completes on edge where mem_req&&mem_ready
- instruction  out  WIDTH  instruction register
- pc_out  out  ADDR_W  current PC
- overflow_output  out  1  signed overflow of last ADD/SUB
- halted  out  1  core stopped
- illegal  out  1  illegal-opcode trap (see Optional Feature)

Behaviour:
- Reset (async, any state): pc=RESET_PC, sp=RESET_SP, mary=shelley=comp=ra=0, instruction=0, overflow=0, halted=0, illegal=0, mem_req=0, state=FETCH.
- Encoding: op=instruction[WIDTH-1:WIDTH-4]; imm=instruction[WIDTH-5:0]; zext/sext to WIDTH.
- Opcodes:
  - 0 NOP.
  - 1 LI: mary=zext(imm).
  - 2 ADD: comp=mary+shelley.
  - 3 SUB: comp=mary-shelley.
  - 4 MOV: shelley=comp.
  - 5 LW: mary=mem[sp+sext(imm)].
  - 6 SW: mem[sp+sext(imm)]=comp.
  - 7 ADDSP: sp+=sext(imm).
  - 8 BEQ: if comp==0, pc+=sext(imm).
  - 9 JAL: ra=pc; pc=zext(imm).
  - A JR: pc=ra.
  - F HALT.
  - B–E illegal.
- Arithmetic: modulo 2^WIDTH. Overflow=signed overflow, updated only by ADD/SUB, held otherwise.
- FSM FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On ready: instruction=mem_rdata, pc=pc+1 (wraps at 2^ADDR_W), go EXEC.
- FSM EXEC:
  - One cycle, mem_req=0.
  - Register/branch ops complete here; BEQ/JAL use the already-incremented pc.
  - LW/SW latch the address, then go MEM.
  - HALT goes to HALTED.
  - All other ops return to FETCH.
- FSM MEM:
  - mem_req=1, mem_we=(SW), mem_addr=latched address, mem_wdata=comp.
  - On ready: LW writes mary; go FETCH.
- FSM HALTED: halted=1, mem_req=0; exits only via reset.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable while waiting.
  - Combinational same-cycle mem_ready is allowed; waits are unbounded.
  - mem_req is never asserted in EXEC or HALTED.
- Latency: register op = 2 cycles minimum (FETCH+EXEC); LW/SW = 3 cycles minimum; plus memory wait cycles.
- Reset mid-MEM SW: mem_req drops immediately (async). Write may be lost; the core never re-issues it.

Optional Feature:
- Macro: MULTICYCLE_CORE_TRAP_ILLEGAL_EN
- Defined: opcodes B–E go to HALTED with illegal=1 (sticky until reset); pc points past the offending word.
- Undefined: B–E execute as NOP; illegal tied 0.

Decomposition:
- Package multicycle_core_pkg:
  - opcode localparams OP_NOP..OP_HALT
  - state encoding FETCH/EXEC/MEM/HALTED
  - field-position functions of WIDTH
- Sub-module: multicycle_core_alu (WIDTH-param, ADD/SUB/pass-through, outputs result, overflow, zero).

Test Plan:
- Reset, then release with mem_ready=1 and word0=0x1005 (LI 5) -> mem_req=1, addr=0, first cycle. Next cycle mary=5, pc=1.
- Overflow sequence: LW from sp-1 holding 0x7FFF, ADD, MOV, LI 1, ADD -> comp=0x8000, overflow_output=1. A following SUB of 0x8000-0x7FFF -> comp=1, overflow=1. A SUB of 1-1 -> overflow=0.
- Fetch with mem_ready low 3 cycles -> mem_req/addr held 4 cycles, pc unchanged until the ready edge, instruction updated once.
- comp=0, BEQ imm=0xFFE at pc=4 -> pc becomes 3. With comp!=0 -> pc=5. JAL 0x020 at pc=7 -> ra=8, pc=0x20. JR -> pc=8.
- HALT -> halted=1 after EXEC, mem_req stays 0 for 20 cycles. Reset -> resumes at RESET_PC.
- Opcode 0xB: with MULTICYCLE_CORE_TRAP_ILLEGAL_EN -> illegal=1, halted=1. Without -> treated as NOP, next fetch at pc+1. Reset asserted during MEM wait -> all outputs at reset values that same cycle.
